// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: central stall/flush/redirect controller for the 5-stage core.
// Merges per-stage stall requests into a contiguous stall vector, issues the
// exception flush, and holds back the PC redirect until any in-flight
// instruction fetch has drained, so a stale fetch never lands in IF/ID.
module pipe_stall_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_valid,
  input  logic [ADDR_W-1:0] excp_target,
  input  logic              ibus_busy,
  output logic [5:0]        stall,
  output logic              flush,
  output logic [ADDR_W-1:0] new_pc,
  output logic              new_pc_valid,
  output logic              drop_fetch,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   target_reg, target_next;
  logic [CNT_W-1:0]    stall_cycles_reg;

  // Output decode and next-state logic; everything is forced quiet during reset.
  always_comb begin
    stall        = 6'b000000;
    flush        = 1'b0;
    new_pc       = '0;
    new_pc_valid = 1'b0;
    drop_fetch   = 1'b0;
    state_next   = state_reg;
    target_next  = target_reg;
    if (!rst) begin
      unique case (state_reg)
        RUN, REDIRECT: begin
          if (excp_valid) begin
            // A newly committed exception overrides stall requests and any
            // pending redirect; the newest target always wins.
            flush       = 1'b1;
            target_next = excp_target;
            if (!ibus_busy) begin
              new_pc       = excp_target;
              new_pc_valid = 1'b1;
              state_next   = RUN;
            end else begin
              state_next = DRAIN;
            end
          end else if (state_reg == REDIRECT) begin
            new_pc       = target_reg;
            new_pc_valid = 1'b1;
            state_next   = RUN;
          end else begin
            // Highest requesting stage freezes itself and everything behind it.
            if (stallreq_mem)     stall = 6'b011111;
            else if (stallreq_ex) stall = 6'b001111;
            else if (stallreq_id) stall = 6'b000111;
            else if (stallreq_if) stall = 6'b000011;
          end
        end
        DRAIN: begin
          // Hold PC/IF while the outstanding fetch returns; its data is junk.
          stall      = 6'b000011;
          drop_fetch = 1'b1;
          if (excp_valid) begin
            flush       = 1'b1;
            target_next = excp_target;
          end
          state_next = ibus_busy ? DRAIN : REDIRECT;
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State, latched redirect target and stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      target_reg       <= '0;
      stall_cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      if (stall != 6'b000000)
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: table-driven check of pipe_stall_ctrl with a scoreboard
// queue of expected outputs and a reference model of the stall counter.
module tb_pipe_stall_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;   // narrow counter so the wrap is reachable quickly

  logic          clk;
  logic          rst;
  logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic          excp_valid;
  logic [AW-1:0] excp_target;
  logic          ibus_busy;
  logic [5:0]    stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          new_pc_valid;
  logic          drop_fetch;
  logic [CW-1:0] stall_cycles;

  pipe_stall_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excp_valid   (excp_valid),
    .excp_target  (excp_target),
    .ibus_busy    (ibus_busy),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .new_pc_valid (new_pc_valid),
    .drop_fetch   (drop_fetch),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [3:0]    req;    // {mem, ex, id, if}
    logic          ev;
    logic [AW-1:0] tgt;
    logic          busy;
    logic [5:0]    e_stall;
    logic          e_flush;
    logic          e_npv;
    logic [AW-1:0] e_pc;
    logic          e_drop;
  } vec_t;

  typedef struct {
    int            id;
    logic [5:0]    stall;
    logic          flush;
    logic          npv;
    logic [AW-1:0] pc;
    logic          chk_pc;
    logic          drop;
    logic [CW-1:0] cnt;
  } exp_t;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] S2 = 6'b000011;
  localparam logic [5:0] S3 = 6'b000111;
  localparam logic [5:0] S4 = 6'b001111;
  localparam logic [5:0] S5 = 6'b011111;

  vec_t          tbl[$];
  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            txn   = 0;
  logic [CW-1:0] exp_cnt = '0;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic ev,
                              input logic [AW-1:0] tgt, input logic busy,
                              input logic [5:0] es, input logic ef, input logic enpv,
                              input logic [AW-1:0] epc, input logic ed);
    vec_t v;
    v.rst = r; v.req = q; v.ev = ev; v.tgt = tgt; v.busy = busy;
    v.e_stall = es; v.e_flush = ef; v.e_npv = enpv; v.e_pc = epc; v.e_drop = ed;
    return v;
  endfunction

  task automatic cmp(input int id, input string name, input logic [AW-1:0] act,
                     input logic [AW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL txn%0d %s actual=%h required=%h", id, name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, check at the negedge,
  // then advance the counter model across the following posedge.
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    rst          = v.rst;
    stallreq_if  = v.req[0];
    stallreq_id  = v.req[1];
    stallreq_ex  = v.req[2];
    stallreq_mem = v.req[3];
    excp_valid   = v.ev;
    excp_target  = v.tgt;
    ibus_busy    = v.busy;
    e.id = txn; e.stall = v.e_stall; e.flush = v.e_flush; e.npv = v.e_npv;
    e.pc = v.e_pc; e.chk_pc = v.e_npv | v.rst; e.drop = v.e_drop; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    $display("txn %0d stall=%b flush=%b npv=%b pc=%h drop=%b cnt=%0d",
             got.id, stall, flush, new_pc_valid, new_pc, drop_fetch, stall_cycles);
    cmp(got.id, "stall", {26'd0, stall}, {26'd0, got.stall});
    cmp(got.id, "flush", {31'd0, flush}, {31'd0, got.flush});
    cmp(got.id, "new_pc_valid", {31'd0, new_pc_valid}, {31'd0, got.npv});
    cmp(got.id, "drop_fetch", {31'd0, drop_fetch}, {31'd0, got.drop});
    cmp(got.id, "stall_cycles", {28'd0, stall_cycles}, {28'd0, got.cnt});
    if (got.chk_pc) cmp(got.id, "new_pc", new_pc, got.pc);
    @(posedge clk);
    if (v.rst) exp_cnt = '0;
    else if (v.e_stall != S0) exp_cnt = exp_cnt + 1'b1;
    txn++;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excp_valid = 0; excp_target = '0; ibus_busy = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with requests active to show they are masked.
    tbl.push_back(mk(1, 4'b1111, 1, 32'h1234_5678, 0, S0, 0, 0, 32'h0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 32'h0, 1, S0, 0, 0, 32'h0, 0));
    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 0, 32'h0, 0));
    // ID + EX together for 3 cycles.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0110, 0, 32'h0, 0, S4, 0, 0, 32'h0, 0));
    // Priority encoding of single and mixed requests.
    tbl.push_back(mk(0, 4'b0001, 0, 32'h0, 0, S2, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 32'h0, 0, S3, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 32'h0, 0, S5, 0, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h0, 1, S5, 0, 0, 32'h0, 0));
    // Exception with idle bus overrides a MEM stall, redirects immediately.
    tbl.push_back(mk(0, 4'b1000, 1, 32'hBFC0_0380, 0, S0, 1, 1, 32'hBFC0_0380, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 0, 32'h0, 0));
    // Exception with busy bus: T0 flush, T1..T3 drain, T4 redirect.
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0180, 1, S0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b1111, 0, 32'h0, 1, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 1, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 32'h0, 0, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 32'h0, 0, S0, 0, 1, 32'h8000_0180, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 0, 32'h0, 0));
    // Second exception during DRAIN replaces the target.
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0100, 1, S0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0200, 1, S2, 1, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 1, 32'h8000_0200, 0));
    // Exception in DRAIN as the bus goes idle: redirect uses the newest target.
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0300, 1, S0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0380, 0, S2, 1, 0, 32'h0, 1));
    // Newer exception arriving in REDIRECT wins with an immediate redirect.
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0400, 0, S0, 1, 1, 32'h8000_0400, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 32'h0, 0, S3, 0, 0, 32'h0, 0));
    // Exception in REDIRECT with a busy bus goes back to DRAIN, then redirects.
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0500, 1, S0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 32'h8000_0600, 1, S0, 1, 0, 32'h0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S2, 0, 0, 32'h0, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 1, 32'h8000_0600, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Counter wrap: stall until the model sits at all-ones, then once more.
    for (int i = 0; i < 40 && exp_cnt != {CW{1'b1}}; i++)
      apply(mk(0, 4'b0001, 0, 32'h0, 0, S2, 0, 0, 32'h0, 0));
    apply(mk(0, 4'b0001, 0, 32'h0, 0, S2, 0, 0, 32'h0, 0));
    apply(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 0, 32'h0, 0));
    cmp(txn, "wrap_to_zero", {28'd0, stall_cycles}, 32'd0);

    // Reset while draining: outputs forced low, then RUN on the next cycle.
    apply(mk(0, 4'b0000, 1, 32'h8000_0700, 1, S0, 1, 0, 32'h0, 0));
    apply(mk(0, 4'b0000, 0, 32'h0, 1, S2, 0, 0, 32'h0, 1));
    apply(mk(1, 4'b1111, 1, 32'h8000_0800, 1, S0, 0, 0, 32'h0, 0));
    apply(mk(0, 4'b0000, 0, 32'h0, 1, S0, 0, 0, 32'h0, 0));
    apply(mk(0, 4'b0000, 0, 32'h0, 0, S0, 0, 0, 32'h0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It issues the one-cycle flush for exceptions detected in MEM. It sequences the PC redirect, waiting until any outstanding instruction-bus fetch has drained, so a stale fetch is never latched into IF/ID.

Parameters:
ADDR_W, 32, width of PC / redirect target
CNT_W, 32, width of stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if  in  1  IF requests stall (icache miss / bus wait)
stallreq_id  in  1  ID requests stall (load-use hazard)
stallreq_ex  in  1  EX requests stall (multi-cycle mult/div)
stallreq_mem  in  1  MEM requests stall (dcache / data bus wait)
excp_valid  in  1  MEM stage commits an exception this cycle
excp_target  in  ADDR_W  handler / ERET return address for that exception
ibus_busy  in  1  an instruction fetch is outstanding on the bus
stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=Stop
flush  out  1  kill all pipeline registers this edge
new_pc  out  ADDR_W  redirect target
new_pc_valid  out  1  PC register loads new_pc this edge
drop_fetch  out  1  IF must discard the returning instruction-bus response
stall_cycles  out  CNT_W  count of cycles with stall != 0

Behaviour:
- Reset (rst=1 at posedge): state=RUN, target_q=0, stall_cycles=0. While rst is high, all combinational outputs are forced to 0 (stall=0, flush=0, new_pc=0, new_pc_valid=0, drop_fetch=0).
- States: RUN, DRAIN, REDIRECT. Outputs are combinational from state and inputs; target_q and state are registered.
- RUN, excp_valid=0: stall from highest requesting stage. mem: 011111; else ex: 001111; else id: 000111; else if: 000011; else 000000. flush=0, new_pc_valid=0.
- RUN, excp_valid=1: flush=1 and stall=000000 this cycle (exception overrides all stall requests). target_q<=excp_target.
  - ibus_busy=0: new_pc=excp_target, new_pc_valid=1 the same cycle; stay in RUN.
  - ibus_busy=1: new_pc_valid=0; next state DRAIN.
- DRAIN: stall=000011 (PC, IF held), flush=0, drop_fetch=1. Stall requests from all stages are ignored.
  - ibus_busy=0: next state REDIRECT.
  - excp_valid=1 in DRAIN: flush=1, target_q<=excp_target; remain in DRAIN (ibus_busy=1) or go to REDIRECT (ibus_busy=0).
- REDIRECT: new_pc=target_q, new_pc_valid=1, stall=000000, flush=0, drop_fetch=0; next state RUN, unconditionally.
  - excp_valid=1 in REDIRECT: the newer exception wins. Apply RUN-with-exception handling using excp_target instead of target_q.
- Redirect latency: 0 cycles if the bus is idle at the exception; otherwise 1 cycle after ibus_busy falls.
- drop_fetch is high only in DRAIN. The response completing in the cycle ibus_busy falls is therefore dropped.
- stall_cycles increments by 1 on every posedge where the stall output is nonzero and rst=0; it wraps from all-ones to 0.
- Reset asserted in any state returns the block to RUN on the next edge; target_q is cleared.
- Stall vectors are always contiguous from bit 0 (000011, 000111, 001111, 011111). A stopped stage never has a running stage behind it.

Test Plan:
- Idle, no requests: stall=000000, flush=0, new_pc_valid=0 for 10 cycles; stall_cycles stays 0.
- stallreq_id=1 and stallreq_ex=1 together for 3 cycles -> stall=001111 each cycle; stall_cycles=3 afterwards.
- excp_valid=1, excp_target=0xBFC00380, ibus_busy=0, stallreq_mem=1 -> same cycle flush=1, stall=000000, new_pc_valid=1, new_pc=0xBFC00380.
- excp_valid=1, target=0x80000180, ibus_busy=1 for 3 more cycles -> flush=1 at T0; stall=000011 and drop_fetch=1 for T1..T3; REDIRECT at T4 with new_pc=0x80000180.
- Second excp_valid (target=0x80000200) during DRAIN -> flush=1 again; REDIRECT later drives new_pc=0x80000200.
- Preload stall_cycles to all-ones via a long stall (or force), one more stalled cycle -> wraps to 0; rst during DRAIN -> next cycle RUN, all outputs 0.
